// File: rtl/s_box_sequencer_if.sv
// Bus bundle for the S-box sequencer: input word stream, result stream and shared lookup port.
// The slave modport is the sequencer's view; the master modport is its environment.
interface s_box_sequencer_if;
  localparam int unsigned WORD_W  = 48;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CHUNK_W = 6;
  localparam int unsigned NIB_W   = 4;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [IDX_W-1:0]   s_box_select;
  logic [CHUNK_W-1:0] s_box_input;
  logic [NIB_W-1:0]   s_box_output;
  logic               busy;

  modport slave (
    input  in_valid, in_data, out_ready, s_box_output,
    output in_ready, out_valid, out_data, s_box_select, s_box_input, busy
  );

  modport master (
    output in_valid, in_data, out_ready, s_box_output,
    input  in_ready, out_valid, out_data, s_box_select, s_box_input, busy
  );
endinterface

// File: rtl/s_box_sequencer.sv
// Time-multiplexed DES round substitution: walks one shared 6-to-4 lookup port through S1..S8
// and assembles the 32-bit result for the P-permutation stage.
module s_box_sequencer #(
  parameter int unsigned LOOKUP_LATENCY = 0
) (
  input  logic             clk,
  input  logic             reset,
  s_box_sequencer_if.slave bus
);
  localparam int unsigned WORD_W  = 48;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CHUNK_W = 6;
  localparam int unsigned NIB_W   = 4;
  localparam bit          REG_LOOKUP = (LOOKUP_LATENCY == 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

  if (LOOKUP_LATENCY > 1) begin : g_bad_latency
    $error("s_box_sequencer: LOOKUP_LATENCY must be 0 or 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_WAIT, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [CHUNK_W-1:0]  sin_q, sin_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                capture_c;
  logic [IDX_W-1:0]    nib_slot_c;

  // Chunk for S-box i sits at word[47-6*i -: 6], i.e. base 6*(7-i).
  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
    logic [IDX_W-1:0] r;
    logic [5:0]       sh;
    r  = LAST_IDX - i;
    sh = {1'b0, r, 2'b00} + {2'b00, r, 1'b0};
    return w[sh +: CHUNK_W];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_LOOKUP;
          idx_d   = '0;
        end
      end
      ST_LOOKUP: begin
        if (REG_LOOKUP)               state_d = ST_WAIT;
        else if (idx_q == LAST_IDX)   state_d = ST_DONE;
        else                          idx_d   = idx_q + IDX_W'(1);
      end
      ST_WAIT: begin
        if (idx_q == LAST_IDX) state_d = ST_DONE;
        else begin
          state_d = ST_LOOKUP;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lookup result is taken in LOOKUP (combinational ROM) or WAIT (registered ROM).
  always_comb begin
    word_d      = word_q;
    data_d      = data_q;
    sel_d       = sel_q;
    sin_d       = sin_q;
    capture_c   = (state_q == ST_WAIT) || ((state_q == ST_LOOKUP) && !REG_LOOKUP);
    nib_slot_c  = LAST_IDX - idx_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    if ((state_q == ST_IDLE) && bus.in_valid) begin
      word_d = bus.in_data;
      sel_d  = '0;
      sin_d  = bus.in_data[WORD_W-1 -: CHUNK_W];
    end
    if (capture_c) begin
      data_d[{nib_slot_c, 2'b00} +: NIB_W] = bus.s_box_output;
      if (idx_q != LAST_IDX) begin
        sel_d = idx_q + IDX_W'(1);
        sin_d = chunk_of(word_q, idx_q + IDX_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      word_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      sin_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      word_q      <= word_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      sin_q       <= sin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = data_q;
  assign bus.s_box_select = sel_q;
  assign bus.s_box_input  = sin_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_s_box_sequencer.sv
// Directed bench for s_box_sequencer: combinational-ROM instance (dut0) and registered-ROM
// instance (dut1) driven by small lookup stubs.
module tb_s_box_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] stub_mode;
  logic       seen_valid;
  int         n_checks = 0;
  int         n_pass   = 0;

  s_box_sequencer_if bus0();
  s_box_sequencer_if bus1();

  s_box_sequencer #(.LOOKUP_LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  s_box_sequencer #(.LOOKUP_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  // DES S5: row = {b5,b0}, column = b4..b1.
  function automatic logic [3:0] s5(input logic [5:0] c);
    logic [63:0] row;
    logic [3:0]  slot;
    case ({c[5], c[0]})
      2'd0:    row = 64'h2C417AB6853FD0E9;
      2'd1:    row = 64'hEB2C47D150FA3986;
      2'd2:    row = 64'h421BAD78F9C5630E;
      default: row = 64'hB8C71E2D6F09A453;
    endcase
    slot = 4'd15 - c[4:1];
    return row[{slot, 2'b00} +: 4];
  endfunction

  always_comb begin
    case (stub_mode)
      2'd1:    bus0.s_box_output = bus0.s_box_input[3:0];
      2'd2:    bus0.s_box_output = (bus0.s_box_select == 3'd4) ? s5(bus0.s_box_input)
                                                               : {1'b0, bus0.s_box_select};
      default: bus0.s_box_output = {1'b0, bus0.s_box_select};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) bus1.s_box_output <= 4'h0;
    else       bus1.s_box_output <= {1'b0, bus1.s_box_select};
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_out0(input int max_cyc);
    int n;
    n = 0;
    while (bus0.out_valid !== 1'b1 && n < max_cyc) begin
      step(1);
      n++;
    end
    check("wait_out_valid", 48'(bus0.out_valid), 48'(1));
  endtask

  // Accept a word on dut0, scramble in_data afterwards, check the result, then handshake.
  task automatic run0(input string tag, input logic [47:0] data, input logic [31:0] exp);
    bus0.in_valid = 1'b1;
    bus0.in_data  = data;
    step(1);
    bus0.in_valid = 1'b0;
    bus0.in_data  = '1;
    wait_out0(30);
    check(tag, 48'(bus0.out_data), 48'(exp));
    bus0.out_ready = 1'b1;
    step(1);
    bus0.out_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    stub_mode      = 2'd0;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b0;
    step(2);
    check("rst_in_ready",  48'(bus0.in_ready),     48'(1));
    check("rst_out_valid", 48'(bus0.out_valid),    48'(0));
    check("rst_out_data",  48'(bus0.out_data),     48'(0));
    check("rst_select",    48'(bus0.s_box_select), 48'(0));
    check("rst_input",     48'(bus0.s_box_input),  48'(0));
    check("rst_busy",      48'(bus0.busy),         48'(0));
    reset = 1'b0;
    step(1);

    // Identity stub, exact 8-cycle latency and select sequence.
    bus0.in_valid = 1'b1;
    bus0.in_data  = '0;
    step(1);
    bus0.in_valid = 1'b0;
    check("id_busy",     48'(bus0.busy),     48'(1));
    check("id_in_ready", 48'(bus0.in_ready), 48'(0));
    for (int k = 0; k < 8; k++) begin
      check("id_select", 48'(bus0.s_box_select), 48'(k));
      if (k == 7) check("id_early_valid", 48'(bus0.out_valid), 48'(0));
      step(1);
    end
    check("id_out_valid", 48'(bus0.out_valid), 48'(1));
    check("id_out_data",  48'(bus0.out_data),  48'(32'h01234567));
    bus0.out_ready = 1'b1;
    step(1);
    bus0.out_ready = 1'b0;
    check("id_idle_valid",  48'(bus0.out_valid),    48'(0));
    check("id_idle_ready",  48'(bus0.in_ready),     48'(1));
    check("id_idle_select", 48'(bus0.s_box_select), 48'(7));

    // Chunk routing: stub echoes the low nibble of the chunk.
    stub_mode = 2'd1;
    run0("route_k", {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}, 32'h01234567);
    run0("route_s1", {6'h3F, 42'd0}, 32'hF0000000);
    check("route_s1_nib", 48'(bus0.out_data[31:28]), 48'(4'hF));

    // Real S5 table on index 4.
    stub_mode = 2'd2;
    run0("s5_zero", 48'd0, 32'h01232567);
    check("s5_zero_nib", 48'(bus0.out_data[15:12]), 48'(4'h2));
    run0("s5_row3", {24'd0, 6'b100001, 18'd0}, 32'h0123B567);
    check("s5_row3_nib", 48'(bus0.out_data[15:12]), 48'(4'hB));

    // Backpressure with in_valid held high throughout DONE.
    stub_mode     = 2'd0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = '0;
    step(1);
    wait_out0(30);
    for (int k = 0; k < 20; k++) begin
      check("bp_valid",    48'(bus0.out_valid), 48'(1));
      check("bp_data",     48'(bus0.out_data),  48'(32'h01234567));
      check("bp_in_ready", 48'(bus0.in_ready),  48'(0));
      step(1);
    end
    bus0.out_ready = 1'b1;
    step(1);
    bus0.out_ready = 1'b0;
    check("hs_valid",    48'(bus0.out_valid), 48'(0));
    check("hs_in_ready", 48'(bus0.in_ready),  48'(1));
    check("hs_busy",     48'(bus0.busy),      48'(0));
    step(1);
    bus0.in_valid = 1'b0;
    check("second_busy",     48'(bus0.busy),     48'(1));
    check("second_in_ready", 48'(bus0.in_ready), 48'(0));
    wait_out0(30);
    check("second_data", 48'(bus0.out_data), 48'(32'h01234567));
    bus0.out_ready = 1'b1;
    step(1);
    bus0.out_ready = 1'b0;

    // Registered lookup: each select held two cycles, 16-cycle latency.
    bus1.in_valid = 1'b1;
    bus1.in_data  = '0;
    step(1);
    bus1.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("reg_select_a", 48'(bus1.s_box_select), 48'(k));
      step(1);
      check("reg_select_b", 48'(bus1.s_box_select), 48'(k));
      if (k == 7) check("reg_early_valid", 48'(bus1.out_valid), 48'(0));
      step(1);
    end
    check("reg_out_valid", 48'(bus1.out_valid), 48'(1));
    check("reg_out_data",  48'(bus1.out_data),  48'(32'h01234567));
    bus1.out_ready = 1'b1;
    step(1);
    bus1.out_ready = 1'b0;
    check("reg_idle_valid", 48'(bus1.out_valid), 48'(0));

    // Reset aborts an operation at index 3.
    bus0.in_valid = 1'b1;
    bus0.in_data  = 48'hFEDCBA987654;
    step(1);
    bus0.in_valid = 1'b0;
    step(3);
    check("abort_select", 48'(bus0.s_box_select), 48'(3));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("abort_in_ready",  48'(bus0.in_ready),  48'(1));
    check("abort_out_valid", 48'(bus0.out_valid), 48'(0));
    check("abort_busy",      48'(bus0.busy),      48'(0));
    check("abort_out_data",  48'(bus0.out_data),  48'(0));
    seen_valid = 1'b0;
    repeat (12) begin
      if (bus0.out_valid === 1'b1) seen_valid = 1'b1;
      step(1);
    end
    check("abort_no_valid", 48'(seen_valid), 48'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
